fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_fifo.sv | 77 +++++++
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcode constants, bubble encoding, fetch FSM states and FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam logic [3:0] OP_HALT   = 4'b0000;
    localparam logic [3:0] OP_NOP    = 4'b0001;
    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [3:0] OP_JUMP   = 4'b0100;

    // Bubble: opcode OP_NOP, all other fields zero.
    localparam logic [15:0] NOP_INST = 16'h1000;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
        logic        filled;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [15:0] inst_word);
        return inst_word[15:12] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: in-order buffer of issued fetches; entries are allocated at request and filled at response.
// Latency: a fill at edge t makes the entry visible as filled at the head from edge t onward.
// Backpressure: none internally; alloc is dropped when full (unless popping), fill is dropped with nothing unfilled.
//
// Ports: clk/rst (sync, active-high); flush clears all entries; alloc/alloc_pc append at the tail;
//        fill/fill_inst complete the oldest unfilled entry; pop retires a filled head;
//        head_* describe the oldest entry; count = allocated entries; unfilled = entries awaiting data.
module fetch_fifo #(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [15:0]      alloc_pc,
    input  logic             fill,
    input  logic [15:0]      fill_inst,
    input  logic             pop,
    output logic [15:0]      head_pc,
    output logic [15:0]      head_inst,
    output logic             head_filled,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] unfilled
);
    import fetch_stage_pkg::*;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic             do_alloc;
    logic             do_fill;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_pc     = mem[head_ptr].pc;
    assign head_inst   = mem[head_ptr].inst;
    // A non-empty FIFO's head was written by alloc, which clears the filled bit.
    assign head_filled = (count != '0) && mem[head_ptr].filled;

    assign do_pop   = pop && head_filled;
    assign do_fill  = fill && (unfilled != '0);
    // When full, the tail slot is the head slot, so allocating alongside a pop reuses it.
    assign do_alloc = alloc && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
            unfilled <= '0;
        end else begin
            if (do_alloc) begin
                mem[tail_ptr] <= '{pc: alloc_pc, inst: 16'h0000, filled: 1'b0};
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            // fill_ptr never equals tail_ptr while an entry is unfilled, so no write clash.
            if (do_fill) begin
                mem[fill_ptr].inst   <= fill_inst;
                mem[fill_ptr].filled <= 1'b1;
                fill_ptr             <= ptr_inc(fill_ptr);
            end
            if (do_pop) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            count    <= count + CNT_W'(do_alloc) - CNT_W'(do_pop);
            unfilled <= unfilled + CNT_W'(do_alloc) - CNT_W'(do_fill);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with in-order memory requests, response FIFO and registered IF/ID output.
// Latency: response at edge t reaches inst/PC after edge t+1 when it is the FIFO head and stall=0.
// Backpressure: stall freezes IF/ID; requests stop once DEPTH entries are outstanding or buffered.
//
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_gnt request channel;
//        imem_rvalid/imem_rdata in-order responses; stall hold; redirect/redirect_pc branch target;
//        PC/PCPlus1/inst/inst_valid IF/ID register; halted when a halt instruction sits in IF/ID.
// Optional: define FETCH_STALL_CNT_EN to add stall_cycles, a saturating count of stalled valid cycles.
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] PC,
    output logic [15:0] PCPlus1,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic        halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);
    import fetch_stage_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [15:0]      fetch_pc;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_nxt;

    logic             fifo_flush;
    logic             fifo_alloc;
    logic             fifo_fill;
    logic             fifo_pop;
    logic [15:0]      fifo_head_pc;
    logic [15:0]      fifo_head_inst;
    logic             fifo_head_filled;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_unfilled;

    logic             if_load;
    logic             if_bubble;

    assign imem_addr  = fetch_pc;
    assign halted     = (state == HALTED);
    assign fifo_alloc = imem_req && imem_gnt;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (fifo_flush),
        .alloc       (fifo_alloc),
        .alloc_pc    (fetch_pc),
        .fill        (fifo_fill),
        .fill_inst   (imem_rdata),
        .pop         (fifo_pop),
        .head_pc     (fifo_head_pc),
        .head_inst   (fifo_head_inst),
        .head_filled (fifo_head_filled),
        .count       (fifo_count),
        .unfilled    (fifo_unfilled)
    );

    always_comb begin
        state_nxt  = state;
        drop_nxt   = drop_cnt;
        imem_req   = 1'b0;
        fifo_flush = 1'b0;
        fifo_fill  = 1'b0;
        fifo_pop   = 1'b0;
        if_load    = 1'b0;
        if_bubble  = 1'b0;

        case (state)
            RUN, HALTED: begin
                if (redirect) begin
                    // Outstanding requests still owe a response each; a response arriving now
                    // is one of them and is discarded immediately.
                    fifo_flush = 1'b1;
                    if_bubble  = 1'b1;
                    drop_nxt   = fifo_unfilled - CNT_W'(imem_rvalid && (fifo_unfilled != '0));
                    state_nxt  = (drop_nxt != '0) ? DRAIN : RUN;
                end else begin
                    fifo_fill = imem_rvalid;
                    if (state == RUN) begin
                        imem_req = (fifo_count < CNT_W'(DEPTH));
                        if (!stall) begin
                            if (fifo_head_filled) begin
                                fifo_pop = 1'b1;
                                if_load  = 1'b1;
                                if (is_halt(fifo_head_inst)) begin
                                    state_nxt = HALTED;
                                end
                            end else begin
                                if_bubble = 1'b1;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                // FIFO is empty here; a redirect only retargets fetch_pc (handled in the register).
                if (!stall) begin
                    if_bubble = 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop_cnt <= CNT_W'(1)) begin
                        drop_nxt  = '0;
                        state_nxt = RUN;
                    end else begin
                        drop_nxt = drop_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            drop_cnt   <= '0;
            fetch_pc   <= RESET_PC;
            PC         <= RESET_PC;
            PCPlus1    <= RESET_PC + 16'd1;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (fifo_alloc) begin
                fetch_pc <= fetch_pc + 16'd1;
            end
            if (if_load) begin
                PC         <= fifo_head_pc;
                PCPlus1    <= fifo_head_pc + 16'd1;
                inst       <= fifo_head_inst;
                inst_valid <= 1'b1;
            end else if (if_bubble) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && inst_valid && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    // A response with no request waiting for it is dropped by the FIFO; flag it in simulation.
    assert property (@(posedge clk) disable iff (rst)
        (imem_rvalid && (state != DRAIN)) |-> (fifo_unfilled != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with an in-order variable-latency memory stub.
// Latency: memory answers lat cycles after acceptance, one response per cycle, in order.
// Backpressure: stall and redirect are driven directly by the directed sequence.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] PC;
    logic [15:0] PCPlus1;
    logic [15:0] inst;
    logic        inst_valid;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    logic        last_req;
    logic [15:0] mem [256];
    logic [15:0] q_addr [$];
    int          q_due  [$];

    fetch_stage #(.DEPTH(2), .RESET_PC(16'hFFFF), .NOP_INST(16'h1000)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .PC           (PC),
        .PCPlus1      (PCPlus1),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .halted       (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, sample the request, advance, book-keep the stub.
    task automatic step();
        logic        acc;
        logic [15:0] a;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[q_addr[0][7:0]];
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
        end
        #1;
        acc      = imem_req && imem_gnt;
        a        = imem_addr;
        last_req = imem_req;
        @(posedge clk);
        cyc++;
        if (imem_rvalid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (acc) begin
            q_addr.push_back(a);
            q_due.push_back(cyc + lat - 1);
        end
        @(negedge clk);
    endtask

    task automatic expect_next(input logic [15:0] epc, input logic [15:0] einst, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!inst_valid && n < 30);
        check({tag, "_valid"}, 16'(inst_valid), 16'h0001);
        check({tag, "_pc"}, PC, epc);
        check({tag, "_pcp1"}, PCPlus1, epc + 16'd1);
        check({tag, "_inst"}, inst, einst);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 16'(imem_req), 16'h0000);
        check({tag, "_addr"}, imem_addr, 16'hFFFF);
        check({tag, "_pc"}, PC, 16'hFFFF);
        check({tag, "_pcp1"}, PCPlus1, 16'h0000);
        check({tag, "_inst"}, inst, 16'h1000);
        check({tag, "_valid"}, 16'(inst_valid), 16'h0000);
        check({tag, "_halted"}, 16'(halted), 16'h0000);
    endtask

    initial begin
        int n;
        int req_cnt;

        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'h30, 8'(i)};
        end
        mem[0] = 16'hC000;
        mem[1] = 16'hD000;
        mem[2] = 16'hE000;
        mem[5] = 16'h0000;

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        @(negedge clk);

        // Reset state, RESET_PC = 0xFFFF.
        repeat (3) step();
        check_reset_outputs("rst");

        rst = 1'b0;
        #1;
        check("first_req", 16'(imem_req), 16'h0001);
        check("first_addr", imem_addr, 16'hFFFF);

        // Sequential fetch with 1-cycle memory, PC wrap from 0xFFFF to 0x0000.
        expect_next(16'hFFFF, 16'h30FF, "wrap");
        expect_next(16'h0000, 16'hC000, "seq0");
        expect_next(16'h0001, 16'hD000, "seq1");
        expect_next(16'h0002, 16'hE000, "seq2");

        // Stall for 4 cycles: IF/ID frozen, requests stop once the FIFO is full.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_pc", PC, 16'h0002);
            check("stall_inst", inst, 16'hE000);
            check("stall_valid", 16'(inst_valid), 16'h0001);
        end
        #1;
        check("stall_req_full", 16'(imem_req), 16'h0000);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cycles", stall_cycles, 16'd4);
`endif
        stall = 1'b0;
        expect_next(16'h0003, 16'h3003, "post_stall3");
        expect_next(16'h0004, 16'h3004, "post_stall4");

        // Halt at PC 5: held regardless of stall, no requests.
        expect_next(16'h0005, 16'h0000, "halt");
        check("halt_flag", 16'(halted), 16'h0001);
        req_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            stall = 1'(i % 2);
            step();
            req_cnt += int'(last_req);
        end
        stall = 1'b0;
        check("halt_no_req", 16'(req_cnt), 16'h0000);
        check("halt_hold_pc", PC, 16'h0005);
        check("halt_hold_pcp1", PCPlus1, 16'h0006);
        check("halt_hold_inst", inst, 16'h0000);
        check("halt_hold_flag", 16'(halted), 16'h0001);

        // Redirect out of HALTED.
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        check("unhalt_flag", 16'(halted), 16'h0000);
        check("unhalt_valid", 16'(inst_valid), 16'h0000);
        check("unhalt_inst", inst, 16'h1000);
        expect_next(16'h0010, 16'h3010, "resume");

        // 3-cycle memory: redirect with 2 outstanding, stale responses dropped.
        lat = 3;
        n = 0;
        while (q_addr.size() != 2 && n < 20) begin
            step();
            n++;
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        check("redir_cycle_req", 16'(last_req), 16'h0000);
        req_cnt = 0;
        n = 0;
        while (q_addr.size() > 0 && n < 20) begin
            step();
            req_cnt += int'(last_req);
            n++;
        end
        check("drain_no_req", 16'(req_cnt), 16'h0000);
        expect_next(16'h0040, 16'h3040, "redir40");

        // Reset with 2 outstanding and stall high; responses arrive during reset.
        n = 0;
        while (q_addr.size() != 2 && n < 20) begin
            step();
            n++;
        end
        stall = 1'b1;
        rst   = 1'b1;
        step();
        check_reset_outputs("rst2");
        repeat (5) step();
        q_addr.delete();
        q_due.delete();
        rst   = 1'b0;
        stall = 1'b0;
        lat   = 1;
        expect_next(16'hFFFF, 16'h30FF, "rst2_first");
        expect_next(16'h0000, 16'hC000, "rst2_second");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
